// File: rtl/spi3_lcd_stream_writer.sv
// 3-wire serial panel writer: runs the RESX power-up sequence, then serialises
// command/data words ({D/C, payload}) on CSX/SCL/SDA, keeping CSX low until in_last.
module spi3_lcd_stream_writer #(
    parameter int CLK_DIV   = 1,
    parameter int WORD_BITS = 8,
    parameter int DC_BIT    = 1,
    parameter int MSB_FIRST = 1,
    parameter int RESX_LOW  = 4,
    parameter int RESX_WAIT = 16
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_dc,
    input  logic [WORD_BITS-1:0] in_data,
    input  logic                 in_last,
    output logic                 busy,
    output logic                 RESX,
    output logic                 CSX,
    output logic                 SCL,
    output logic                 SDA
);

    localparam int F    = WORD_BITS + DC_BIT;
    localparam int BW   = $clog2(F + 1);
    localparam int DW   = $clog2(CLK_DIV + 1);
    localparam int RMAX = (RESX_LOW > RESX_WAIT) ? RESX_LOW : RESX_WAIT;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(F - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [RW-1:0] LOW_LAST  = RW'(RESX_LOW - 1);
    localparam logic [RW-1:0] WAIT_LAST = RW'(RESX_WAIT - 1);

    typedef enum logic [2:0] {
        RST_LOW,
        RST_WAIT,
        IDLE,
        SHIFT,
        HOLD,
        TAIL
    } state_t;

    state_t          state;
    logic [RW-1:0]   rcnt;
    logic [DW-1:0]   div;
    logic [BW-1:0]   bitn;
    logic            last_q;
    logic            tail_hi;
    logic [F-1:0]    shreg;
    logic [F-1:0]    frame_in;
    logic            accept;
    logic            bit_adv;

    function automatic logic [WORD_BITS-1:0] order_payload(input logic [WORD_BITS-1:0] d);
        logic [WORD_BITS-1:0] r;
        for (int i = 0; i < WORD_BITS; i++)
            r[i] = (MSB_FIRST != 0) ? d[i] : d[WORD_BITS-1-i];
        return r;
    endfunction

    // The frame is stored so that its first transmitted bit is always the top bit.
    generate
        if (DC_BIT != 0) begin : g_dc
            assign frame_in = {in_dc, order_payload(in_data)};
        end else begin : g_nodc
            logic unused_dc;
            assign unused_dc = in_dc;
            assign frame_in  = order_payload(in_data);
        end
    endgenerate

    assign accept  = in_valid && in_ready;
    assign bit_adv = (state == SHIFT) && SCL && (div == DIV_LAST) && (bitn != BIT_LAST);

    // Payload shifter: data path only, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (accept)
            shreg <= frame_in << 1;
        else if (bit_adv)
            shreg <= shreg << 1;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= RST_LOW;
            rcnt     <= '0;
            div      <= '0;
            bitn     <= '0;
            last_q   <= 1'b0;
            tail_hi  <= 1'b0;
            RESX     <= 1'b0;
            CSX      <= 1'b1;
            SCL      <= 1'b0;
            SDA      <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
        end else begin
            case (state)
                RST_LOW: begin
                    if (rcnt == LOW_LAST) begin
                        rcnt  <= '0;
                        RESX  <= 1'b1;
                        state <= RST_WAIT;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                RST_WAIT: begin
                    if (rcnt == WAIT_LAST) begin
                        rcnt     <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                IDLE, HOLD: begin
                    if (accept) begin
                        CSX      <= 1'b0;
                        SCL      <= 1'b0;
                        SDA      <= frame_in[F-1];
                        last_q   <= in_last;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        div      <= '0;
                        bitn     <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div != DIV_LAST) begin
                        div <= div + 1'b1;
                    end else begin
                        div <= '0;
                        if (!SCL) begin
                            SCL <= 1'b1;
                        end else begin
                            // Falling edge: the only point where SDA may move.
                            SCL <= 1'b0;
                            if (bitn == BIT_LAST) begin
                                SDA <= 1'b0;
                                if (last_q) begin
                                    tail_hi <= 1'b0;
                                    state   <= TAIL;
                                end else begin
                                    in_ready <= 1'b1;
                                    state    <= HOLD;
                                end
                            end else begin
                                bitn <= bitn + 1'b1;
                                SDA  <= shreg[F-1];
                            end
                        end
                    end
                end
                TAIL: begin
                    if (div != DIV_LAST) begin
                        div <= div + 1'b1;
                    end else begin
                        div <= '0;
                        if (!tail_hi) begin
                            CSX     <= 1'b1;
                            tail_hi <= 1'b1;
                        end else begin
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= RST_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_spi3_lcd_stream_writer.sv
// Randomised bench for spi3_lcd_stream_writer: a queue-based model of the bits the panel
// should sample, checked at every SCL rise, plus directed reset/framing/timing checks.
module tb_spi3_lcd_stream_writer;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b1;
    logic        in_valid = 1'b0, in_dc = 1'b0, in_last = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, busy, RESX, CSX, SCL, SDA;
    logic        px_valid = 1'b0, px_last = 1'b0;
    logic [17:0] px_data = '0;
    logic        px_ready, px_busy, px_resx, px_csx, px_scl, px_sda;

    int n_chk = 0, n_err = 0, cyc = 0;
    bit mon_en = 0;
    bit exp_q[$];
    bit px_q[$];
    int m_rises = 0, exp_rises = 0, px_rises = 0, px_exp_rises = 0;
    int last_fall_cyc = 0, px_run = 0;
    bit pend_rdy = 0;
    logic m_scl = 0, m_sda = 0, m_csx = 1, px_pscl = 0, px_pcsx = 1;

    always #5 CLK = ~CLK;

    spi3_lcd_stream_writer dut (
        .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready), .in_dc(in_dc),
        .in_data(in_data), .in_last(in_last), .busy(busy), .RESX(RESX), .CSX(CSX),
        .SCL(SCL), .SDA(SDA));

    spi3_lcd_stream_writer #(.CLK_DIV(3), .WORD_BITS(18), .DC_BIT(0)) dut_px (
        .CLK(CLK), .RSTN(RSTN), .in_valid(px_valid), .in_ready(px_ready), .in_dc(1'b0),
        .in_data(px_data), .in_last(px_last), .busy(px_busy), .RESX(px_resx), .CSX(px_csx),
        .SCL(px_scl), .SDA(px_sda));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: bits in wire order, D/C first, payload in the configured order.
    task automatic model_push(input bit px, input logic dc, input logic [31:0] d,
                              input int wbits, input bit dcbit, input bit msb);
        if (dcbit) begin
            if (px) px_q.push_back(dc); else exp_q.push_back(dc);
        end
        for (int i = 0; i < wbits; i++) begin
            int idx;
            idx = msb ? (wbits - 1 - i) : i;
            if (px) px_q.push_back(d[idx]); else exp_q.push_back(d[idx]);
        end
    endtask

    always @(negedge CLK) begin
        cyc++;
        if (mon_en && RSTN) begin
            if (pend_rdy) begin
                check("ready_after_deselect", in_ready, 1);
                pend_rdy = 0;
            end
            if (!m_scl && SCL) begin
                m_rises++;
                check("csx_at_rise", CSX, 0);
                if (exp_q.size() == 0) check("stray_rise", 1, 0);
                else check("sda_bit", SDA, exp_q.pop_front());
            end
            if (m_scl && SCL) check("sda_stable", SDA, m_sda);
            if (m_scl && !SCL) last_fall_cyc = cyc;
            if (CSX && m_csx) check("idle_lines", {SCL, SDA}, 0);
            if (!m_csx && CSX) begin
                check("rises_per_txn", m_rises, exp_rises);
                check("csx_after_fall", cyc - last_fall_cyc, 1);
                check("queue_drained", exp_q.size(), 0);
                m_rises = 0; exp_rises = 0; pend_rdy = 1;
            end
            // pixel instance: phase lengths and bit order
            if (px_pcsx && !px_csx) px_run = 0;
            if (px_scl != px_pscl) begin
                if (!px_csx) check(px_scl ? "px_low_len" : "px_high_len", px_run, 3);
                px_run = 1;
                if (px_scl) begin
                    px_rises++;
                    if (px_q.size() == 0) check("px_stray_rise", 1, 0);
                    else check("px_sda_bit", px_sda, px_q.pop_front());
                end
            end else begin
                px_run++;
            end
            if (!px_pcsx && px_csx) begin
                check("px_rises_per_txn", px_rises, px_exp_rises);
                px_rises = 0; px_exp_rises = 0;
            end
        end
        m_scl = SCL; m_sda = SDA; m_csx = CSX; px_pscl = px_scl; px_pcsx = px_csx;
    end

    task automatic do_reset();
        int low, wt;
        bit lines_ok;
        @(posedge CLK); #2;
        RSTN = 1'b0;
        #1;
        check("rst_async_resx", RESX, 0);
        check("rst_async_csx", CSX, 1);
        check("rst_async_scl_sda", {SCL, SDA}, 0);
        exp_q.delete(); px_q.delete();
        m_rises = 0; exp_rises = 0; px_rises = 0; px_exp_rises = 0; pend_rdy = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ready_busy", {in_ready, busy}, 2'b01);
        @(posedge CLK); #1;
        RSTN = 1'b1;
        mon_en = 1;
        low = 0; wt = 0; lines_ok = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (!CSX || SCL) lines_ok = 0;
            if (!RESX) low++;
            else if (!in_ready) wt++;
            else break;
        end
        check("resx_low_cycles", low, 4);
        check("ready_delay", wt, 16);
        check("rst_lines_idle", lines_ok, 1);
        check("px_ready_after_rst", px_ready, 1);
        @(posedge CLK); #1;
    endtask

    task automatic send(input logic dc, input logic [7:0] d, input logic last);
        int n;
        logic acc;
        in_dc = dc; in_data = d; in_last = last; in_valid = 1'b1;
        n = 0; acc = 1'b0;
        while (!acc && n < 400) begin
            @(negedge CLK); acc = in_ready;
            @(posedge CLK); #1;
            n++;
        end
        if (!acc) check("accept_timeout", 0, 1);
        else begin
            model_push(0, dc, {24'd0, d}, 8, 1, 1);
            exp_rises += 9;
        end
        in_valid = 1'b0; in_data = 8'($urandom); in_dc = 1'($urandom); in_last = 1'($urandom);
    endtask

    task automatic px_send(input logic [17:0] d);
        int n;
        logic acc;
        px_data = d; px_last = 1'b1; px_valid = 1'b1;
        n = 0; acc = 1'b0;
        while (!acc && n < 400) begin
            @(negedge CLK); acc = px_ready;
            @(posedge CLK); #1;
            n++;
        end
        if (!acc) check("px_accept_timeout", 0, 1);
        else begin
            model_push(1, 1'b0, {14'd0, d}, 18, 0, 1);
            px_exp_rises += 18;
        end
        px_valid = 1'b0; px_data = 18'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin @(negedge CLK); n++; end
        while (!(in_ready && CSX && !busy && px_ready && px_csx) && n < 1000);
        check("idle_reached", in_ready && CSX && !busy && px_ready && px_csx, 1);
        @(posedge CLK); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int nw, n;
        do_reset();

        px_send(18'h20E31);
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            px_send(18'($urandom));
            wait_idle();
        end

        send(1'b0, 8'h2C, 1'b1);
        wait_idle();

        send(1'b0, 8'h2C, 1'b0);
        send(1'b1, 8'hA5, 1'b1);
        wait_idle();

        send(1'b0, 8'h11, 1'b0);
        n = 0;
        do begin @(negedge CLK); n++; end while (!in_ready && n < 200);
        ok = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (CSX || SCL || !in_ready) ok = 0;
        end
        check("hold_stall", ok, 1);
        @(posedge CLK); #1;
        send(1'b1, 8'h3A, 1'b1);
        wait_idle();

        for (int t = 0; t < 25; t++) begin
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) begin
                send(1'($urandom), 8'($urandom), k == nw - 1);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 6)) @(posedge CLK);
                    #1;
                end
            end
            wait_idle();
        end

        send(1'b1, 8'hC3, 1'b1);
        n = 0;
        while (m_rises < 3 && n < 200) begin @(negedge CLK); n++; end
        check("reach_bit4", m_rises, 3);
        do_reset();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (SCL) n++;
        end
        check("no_stray_scl", n, 0);
        @(posedge CLK); #1;
        send(1'b0, 8'h5E, 1'b1);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
